pdm_adc: RTL and testbench

Capture-side counterpart to the PWM `dac`. It turns a 1-bit comparator stream from an external RC integrator into BITDEPTH-bit unsigned PCM samples, one per `sample_clock` period. The fed-back bit drives the RC network, which closes a first-order delta-sigma loop. It sits beside `sample_clock` and shares its tick, so captured audio is sample-aligned with the synth chain and can be mixed or monitored at SAMPLEFREQ.

---
 rtl/pdm_adc.sv | 136 +++++++++++++
 tb/tb_pdm_adc.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pdm_adc.sv
// pdm_adc: first-order delta-sigma capture front end.
// Synchronises a comparator bit stream, feeds it back to the RC integrator,
// counts ones per sample_clock window and presents the scaled count as an
// unsigned offset-binary PCM sample through a valid/ready output.
// Optional build macro: PDM_ADC_SMOOTH_EN averages each sample with the
// previous one (two-tap box filter).
module pdm_adc #(
  parameter int BITDEPTH        = 14,
  parameter int SAMPLECLOCK_DIV = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clock,
  input  logic                pdm_in,
  output logic                fb_out,
  output logic [BITDEPTH-1:0] pcm,
  output logic                pcm_valid,
  input  logic                pcm_ready,
  output logic                overrun,
  output logic                state_dbg
);

  localparam int CW = SAMPLECLOCK_DIV + 1;
  localparam logic [CW-1:0] FULL = CW'(1) << SAMPLECLOCK_DIV;

  typedef enum logic {
    ARM = 1'b0,
    RUN = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic                  pdm_meta;
  logic                  pdm_s;
  logic                  sc_d;
  logic                  tick;
  logic                  sample_fire;
  logic [CW-1:0]         ones;
  logic [BITDEPTH-1:0]   scaled;
  logic [BITDEPTH-1:0]   out_val;

  // Two-flop synchroniser on the comparator, then one more flop for feedback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pdm_meta <= 1'b0;
      pdm_s    <= 1'b0;
      fb_out   <= 1'b0;
    end else begin
      pdm_meta <= pdm_in;
      pdm_s    <= pdm_meta;
      fb_out   <= pdm_s;
    end
  end

  // Delay sample_clock by one cycle for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sc_d <= 1'b0;
    else      sc_d <= sample_clock;
  end

  assign tick = sample_clock & ~sc_d;

  // Ones counter; on a tick the current bit already belongs to the new window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones <= '0;
    end else if (tick) begin
      ones <= {{SAMPLECLOCK_DIV{1'b0}}, pdm_s};
    end else if (pdm_s && (ones != FULL)) begin
      ones <= ones + CW'(1);
    end
  end

  // State register: ARM discards the partial first window, RUN emits samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARM;
    else      state <= state_nx;
  end

  // Next-state logic and sample strobe.
  always_comb begin
    state_nx    = state;
    sample_fire = 1'b0;
    case (state)
      ARM: if (tick) state_nx = RUN;
      RUN: sample_fire = tick;
      default: state_nx = ARM;
    endcase
  end

  assign state_dbg = state;

  // Scale the closed-window count to full width; a saturated window maps to all ones.
  always_comb begin
    if (ones == FULL) scaled = '1;
    else              scaled = BITDEPTH'(ones[SAMPLECLOCK_DIV-1:0]) << (BITDEPTH - SAMPLECLOCK_DIV);
  end

`ifdef PDM_ADC_SMOOTH_EN
  logic [BITDEPTH-1:0] prev;
  logic [BITDEPTH:0]   sum;

  // Average with the previous scaled sample at one extra bit so nothing overflows.
  always_comb begin
    sum     = {1'b0, scaled} + {1'b0, prev};
    out_val = sum[BITDEPTH:1];
  end

  // Remember the unfiltered sample for the next average.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             prev <= '0;
    else if (sample_fire) prev <= scaled;
  end
`else
  assign out_val = scaled;
`endif

  // Output handshake: a transfer occurs on any cycle with pcm_valid and
  // pcm_ready both high; pcm is held while valid and not transferred; a new
  // sample always loads pcm (keeping valid high), and flags overrun if the
  // old one was still pending with pcm_ready low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcm       <= '0;
      pcm_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (sample_fire) begin
      pcm       <= out_val;
      pcm_valid <= 1'b1;
      if (pcm_valid && !pcm_ready) overrun <= 1'b1;
    end else if (pcm_valid && pcm_ready) begin
      pcm_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_adc.sv
// tb_pdm_adc: directed windows with hand-computed sample values, a
// scoreboard queue filled by the stimulus and drained by a monitor.
module tb_pdm_adc;

  localparam int BD   = 14;
  localparam int ZERO = 0;
  localparam int ONE  = 1;
  localparam int TOG  = 2;
  localparam int P64  = 3;
  localparam int P192 = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          sample_clock;
  logic          pdm_in;
  logic          pcm_ready;
  logic          fb_out;
  logic [BD-1:0] pcm;
  logic          pcm_valid;
  logic          overrun;
  logic          state_dbg;

  logic [BD-1:0] exp_q[$];
  logic [BD-1:0] exp_v;
  logic [BD-1:0] p_model  = '0;
  logic [BD-1:0] last_exp = '0;
  logic [3:0]    hist     = '0;
  logic          rdy_var  = 1'b1;
  bit            fb_chk   = 1'b0;
  int            fb_bad   = 0;
  int            n_vec    = 0;
  int            n_err    = 0;

  pdm_adc #(.BITDEPTH(BD), .SAMPLECLOCK_DIV(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_clock (sample_clock),
    .pdm_in       (pdm_in),
    .fb_out       (fb_out),
    .pcm          (pcm),
    .pcm_valid    (pcm_valid),
    .pcm_ready    (pcm_ready),
    .overrun      (overrun),
    .state_dbg    (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input int pat, input int k);
    case (pat)
      ONE:     return 1'b1;
      TOG:     return (k % 2) == 0;
      P64:     return k < 64;
      P192:    return k < 192;
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive just after the rising edge, look at fb_out on the falling edge.
  task automatic cyc(input logic sc, input logic d);
    @(posedge clk);
    #1;
    sample_clock = sc;
    pdm_in       = d;
    pcm_ready    = rdy_var;
    hist         = {hist[2:0], d};
    @(negedge clk);
    if (fb_chk && (fb_out !== hist[3])) fb_bad++;
  endtask

  // Reference for one produced sample given the raw scaled window value.
  task automatic produce(input logic [BD-1:0] s, input bit push);
`ifdef PDM_ADC_SMOOTH_EN
    last_exp = BD'(({1'b0, s} + {1'b0, p_model}) >> 1);
    p_model  = s;
`else
    last_exp = s;
`endif
    if (push) exp_q.push_back(last_exp);
  endtask

  // 256-cycle window; its opening tick closes the previous window (value s).
  task automatic window(input int pat, input bit prod, input bit push,
                        input logic [BD-1:0] s, input bit chk_nov);
    for (int k = 0; k < 256; k++) begin
      if (k == 0 && prod) produce(s, push);
      cyc(k == 0, pat_bit(pat, k));
      if (k == 1 && chk_nov) check("no_sample_arm", 32'(pcm_valid), 32'd0);
    end
  endtask

  // Monitor: every transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b1 && pcm_valid === 1'b1 && pcm_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_sample: got pcm %h, expected no sample", pcm);
      end else begin
        exp_v = exp_q.pop_front();
        if (pcm !== exp_v) begin
          n_err++;
          $display("FAIL sample: got pcm %h, expected %h", pcm, exp_v);
        end
      end
    end
  end

  initial begin
    rst          = 1'b0;
    sample_clock = 1'b0;
    pdm_in       = 1'b0;
    pcm_ready    = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);
    check("rst_pcm",     32'(pcm),       32'd0);
    check("rst_valid",   32'(pcm_valid), 32'd0);
    check("rst_overrun", 32'(overrun),   32'd0);
    check("rst_fb",      32'(fb_out),    32'd0);
    check("rst_state",   32'(state_dbg), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1);
      if (i == 4) fb_chk = 1'b1;
    end

    // Constant one: first tick arms, then full-scale samples.
    window(ONE, 1'b0, 1'b0, 14'h0000, 1'b1);
    window(ONE, 1'b1, 1'b1, 14'h3FFF, 1'b0);
    window(ONE, 1'b1, 1'b1, 14'h3FFF, 1'b0);
    window(ONE, 1'b1, 1'b1, 14'h3FFF, 1'b0);

    // Constant zero: two trailing ones leak into the first zero window.
    window(ZERO, 1'b1, 1'b1, 14'h3FFF, 1'b0);
    window(ZERO, 1'b1, 1'b1, 14'h0080, 1'b0);
    window(ZERO, 1'b1, 1'b1, 14'h0000, 1'b0);
    check("fb_zero", 32'(fb_out), 32'd0);

    // Toggling input: first window holds 127 ones, steady state 128.
    window(TOG, 1'b1, 1'b1, 14'h0000, 1'b0);
    window(TOG, 1'b1, 1'b1, 14'h1FC0, 1'b0);
    window(TOG, 1'b1, 1'b1, 14'h2000, 1'b0);
    check("fb_follow", 32'(fb_bad), 32'd0);
    fb_bad = 0;
    window(ZERO, 1'b1, 1'b1, 14'h2000, 1'b0);
    window(P64,  1'b1, 1'b1, 14'h0040, 1'b0);

    // Overrun: W=64 sample left pending, then replaced by W=192.
    rdy_var = 1'b0;
    window(P192, 1'b1, 1'b0, 14'h1000, 1'b0);
    check("hold_pcm",     32'(pcm),       32'(last_exp));
    check("hold_valid",   32'(pcm_valid), 32'd1);
    check("hold_overrun", 32'(overrun),   32'd0);
    for (int k = 0; k < 256; k++) begin
      if (k == 0) produce(14'h3000, 1'b1);
      if (k == 10) rdy_var = 1'b1;
      cyc(k == 0, 1'b0);
      if (k == 5) begin
        check("ovr_flag",  32'(overrun),   32'd1);
        check("ovr_pcm",   32'(pcm),       32'(last_exp));
        check("ovr_valid", 32'(pcm_valid), 32'd1);
      end
      if (k == 11) check("valid_drop", 32'(pcm_valid), 32'd0);
    end

    // Reset at cycle 100 of a window of ones.
    for (int k = 0; k < 100; k++) begin
      if (k == 0) produce(14'h0000, 1'b1);
      cyc(k == 0, 1'b1);
    end
    #2;
    rst     = 1'b0;
    fb_chk  = 1'b0;
    p_model = '0;
    #1;
    check("mid_rst_pcm",     32'(pcm),       32'd0);
    check("mid_rst_valid",   32'(pcm_valid), 32'd0);
    check("mid_rst_overrun", 32'(overrun),   32'd0);
    check("mid_rst_fb",      32'(fb_out),    32'd0);
    check("mid_rst_state",   32'(state_dbg), 32'd0);
    repeat (4) cyc(1'b0, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1);
      if (i == 4) fb_chk = 1'b1;
    end
    window(ONE, 1'b0, 1'b0, 14'h0000, 1'b1);
    window(ONE, 1'b1, 1'b1, 14'h3FFF, 1'b0);
    repeat (8) cyc(1'b0, 1'b1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("fb_final",      32'(fb_bad),       32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
